// File: rtl/or_event_counter.sv
// Synchronises two raw request lines, debounces their OR, and counts qualified rising edges with a sticky irq.
// Optional build macro OR_EVT_SAT_EN: the counter saturates at all-ones instead of wrapping.
module or_event_counter #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             irq_ack,
    input  logic             cnt_clr,
    output logic             level,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] count,
    output logic             irq,
    output logic             ovf
);

    localparam int unsigned TW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] TMAX = TW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    logic          a_s1, a_s2, b_s1, b_s2;
    logic          c_sync;
    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          evt_c;

    // Two-flop synchronisers per raw line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= a;
            a_s2 <= a_s1;
            b_s1 <= b;
            b_s2 <= b_s1;
        end
    end

    assign c_sync = a_s2 | b_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            level     <= 1'b0;
            evt_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            level     <= (state_nxt == HIGH) || (state_nxt == QUAL_LO);
            evt_pulse <= evt_c;
        end
    end

    // Debounce next-state; an event is the accepted QUAL_HI -> HIGH step.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        evt_c     = 1'b0;
        unique case (state)
            IDLE: begin
                if (c_sync) begin
                    state_nxt = QUAL_HI;
                    timer_nxt = '0;
                end
            end
            QUAL_HI: begin
                if (!c_sync) begin
                    state_nxt = IDLE;
                end else if (timer == TMAX) begin
                    state_nxt = HIGH;
                    evt_c     = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            HIGH: begin
                if (!c_sync) begin
                    state_nxt = QUAL_LO;
                    timer_nxt = '0;
                end
            end
            QUAL_LO: begin
                if (c_sync) begin
                    state_nxt = HIGH;
                end else if (timer == TMAX) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Event counter; a clear coinciding with an event leaves the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (cnt_clr) begin
            count <= evt_c ? CNT_W'(1) : '0;
            ovf   <= 1'b0;
        end else if (evt_c) begin
`ifdef OR_EVT_SAT_EN
            if (&count) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
`else
            if (&count) begin
                ovf <= 1'b1;
            end
            count <= count + CNT_W'(1);
`endif
        end
    end

    // Sticky irq: a new event beats a simultaneous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (evt_c) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end

endmodule
